mem_stage: RTL and testbench

- Memory stage of the 5-stage RV32I pipeline. It is the consumer of the EX stage result bundle.
- Contains the EX/MEM pipeline register and a load/store unit (LSU) with a request/response handshake to data memory.
- Aligns loads by byte lane and sign- or zero-extends them; generates store byte enables.
- Drives the MEM-side forwarding feedback (rf_en, rd, opr_res) back to EX, raises a pipeline stall while a memory access is outstanding, and presents results to WB.

---
 rtl/mem_stage.sv | 126 ++++++++++++
 tb/tb_mem_stage.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// mem_stage: RV32I memory stage with EX/MEM register, LSU handshake FSM and load/store lane logic.
// Define MEM_MISALIGN_TRAP_EN to add the misalign output and suppress misaligned accesses.
module mem_stage #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] ex_opr_res,
    input  logic [DATA_WIDTH-1:0] ex_opr_b,
    input  logic [4:0]            ex_rd,
    input  logic [DATA_WIDTH-1:0] ex_pc4,
    input  logic                  ex_rf_en,
    input  logic                  ex_dm_en,
    input  logic [1:0]            ex_wb_sel,
    input  logic [2:0]            ex_lsuop,
    output logic                  dmem_req,
    output logic                  dmem_we,
    output logic [ADDR_WIDTH-1:0] dmem_addr,
    output logic [3:0]            dmem_be,
    output logic [DATA_WIDTH-1:0] dmem_wdata,
    input  logic                  dmem_rvalid,
    input  logic [DATA_WIDTH-1:0] dmem_rdata,
    output logic                  stall,
    output logic                  fwd_rf_en,
    output logic [4:0]            fwd_rd,
    output logic [DATA_WIDTH-1:0] fwd_opr_res,
    output logic                  wb_rf_en,
    output logic [4:0]            wb_rd,
    output logic [1:0]            wb_sel,
    output logic [DATA_WIDTH-1:0] wb_opr_res,
    output logic [DATA_WIDTH-1:0] wb_pc4,
    output logic [DATA_WIDTH-1:0] wb_ld_data
`ifdef MEM_MISALIGN_TRAP_EN
    ,
    output logic                  misalign
`endif
);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    state_t state, state_next;
    logic [DATA_WIDTH-1:0] opr_res, opr_b, pc4, ld_q, ld_ext;
    logic [4:0] rd;
    logic rf_en, dm_en, mem_op, mis, issue, is_b, is_h;
    logic [1:0] sel, lane;
    logic [2:0] lsuop;
    logic [7:0] rd_b;
    logic [15:0] rd_h;
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            opr_res <= '0;
            opr_b   <= '0;
            pc4     <= '0;
            rd      <= '0;
            rf_en   <= 1'b0;
            dm_en   <= 1'b0;
            sel     <= '0;
            lsuop   <= '0;
        end else if (!stall) begin
            opr_res <= ex_opr_res;
            opr_b   <= ex_opr_b;
            pc4     <= ex_pc4;
            rd      <= ex_rd;
            rf_en   <= ex_rf_en;
            dm_en   <= ex_dm_en;
            sel     <= ex_wb_sel;
            lsuop   <= ex_lsuop;
        end
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            ld_q  <= '0;
        end else begin
            state <= state_next;
            if (state == BUSY && dmem_rvalid) ld_q <= ld_ext;
        end
    end
    assign mem_op = dm_en | (sel == 2'b10);
    assign lane   = opr_res[1:0];
    assign is_b   = lsuop[1:0] == 2'b00;
    assign is_h   = lsuop[1:0] == 2'b01;
`ifdef MEM_MISALIGN_TRAP_EN
    assign mis      = mem_op & ((is_h & lane[0]) | (lsuop[1] & (lane != 2'b00)));
    assign misalign = mis;
`else
    assign mis = 1'b0;
`endif
    assign issue = mem_op & ~mis;
    always_comb begin
        state_next = state;
        stall      = 1'b0;
        dmem_req   = 1'b0;
        case (state)
            IDLE: begin
                dmem_req   = issue;
                stall      = issue;
                state_next = issue ? BUSY : IDLE;
            end
            BUSY: begin
                dmem_req   = 1'b1;
                stall      = 1'b1;
                state_next = dmem_rvalid ? DONE : BUSY;
            end
            default: state_next = IDLE;
        endcase
    end
    // Halfwords use the aligned lane pair, so misaligned H falls back to {addr[1],0}
    assign dmem_we    = dm_en;
    assign dmem_addr  = {opr_res[ADDR_WIDTH-1:2], 2'b00};
    assign dmem_be    = !mem_op ? 4'b0000 : !dm_en ? 4'b1111 :
                        is_b ? 4'b0001 << lane : is_h ? 4'b0011 << {lane[1], 1'b0} : 4'b1111;
    assign dmem_wdata = is_b ? {4{opr_b[7:0]}} : is_h ? {2{opr_b[15:0]}} : opr_b;
    assign rd_b       = dmem_rdata[{lane, 3'b000} +: 8];
    assign rd_h       = dmem_rdata[{lane[1], 4'b0000} +: 16];
    assign ld_ext     = is_b ? {{(DATA_WIDTH-8){~lsuop[2] & rd_b[7]}}, rd_b} :
                        is_h ? {{(DATA_WIDTH-16){~lsuop[2] & rd_h[15]}}, rd_h} : dmem_rdata;
    assign fwd_rf_en   = rf_en & ~stall;
    assign fwd_rd      = rd;
    assign fwd_opr_res = opr_res;
    assign wb_rf_en    = rf_en & ~stall & ~mis;
    assign wb_rd       = rd;
    assign wb_sel      = sel;
    assign wb_opr_res  = opr_res;
    assign wb_pc4      = pc4;
    assign wb_ld_data  = ld_q;
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed plus random load/store sequences checked against an arithmetic LSU model.
module tb_mem_stage;
    logic clk = 1'b0;
    logic rst_n;
    logic [31:0] ex_opr_res, ex_opr_b, ex_pc4, dmem_addr, dmem_wdata, dmem_rdata;
    logic [31:0] fwd_opr_res, wb_opr_res, wb_pc4, wb_ld_data;
    logic [4:0] ex_rd, fwd_rd, wb_rd;
    logic ex_rf_en, ex_dm_en, dmem_req, dmem_we, dmem_rvalid, stall, fwd_rf_en, wb_rf_en;
    logic [1:0] ex_wb_sel, wb_sel;
    logic [2:0] ex_lsuop;
    logic [3:0] dmem_be;
`ifdef MEM_MISALIGN_TRAP_EN
    logic misalign;
`endif
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_stage dut (
        .clk(clk), .rst_n(rst_n),
        .ex_opr_res(ex_opr_res), .ex_opr_b(ex_opr_b), .ex_rd(ex_rd), .ex_pc4(ex_pc4),
        .ex_rf_en(ex_rf_en), .ex_dm_en(ex_dm_en), .ex_wb_sel(ex_wb_sel), .ex_lsuop(ex_lsuop),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_be(dmem_be),
        .dmem_wdata(dmem_wdata), .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
        .stall(stall), .fwd_rf_en(fwd_rf_en), .fwd_rd(fwd_rd), .fwd_opr_res(fwd_opr_res),
        .wb_rf_en(wb_rf_en), .wb_rd(wb_rd), .wb_sel(wb_sel), .wb_opr_res(wb_opr_res),
        .wb_pc4(wb_pc4), .wb_ld_data(wb_ld_data)
`ifdef MEM_MISALIGN_TRAP_EN
        , .misalign(misalign)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] exp_load(input logic [2:0] op, input logic [31:0] a, input logic [31:0] d);
        logic [31:0] v;
        case (op)
            3'd0, 3'd4: begin
                v = (d >> (8 * (a % 4))) % 256;
                if (op == 3'd0 && v >= 128) v = v - 256;
            end
            3'd1, 3'd5: begin
                v = (d >> (16 * ((a % 4) / 2))) % 65536;
                if (op == 3'd1 && v >= 32768) v = v - 65536;
            end
            default: v = d;
        endcase
        return v;
    endfunction

    function automatic logic [31:0] exp_be(input bit st, input logic [2:0] op, input logic [31:0] a);
        if (!st || op == 3'd2) return 32'd15;
        if (op == 3'd0) return 32'd1 << (a % 4);
        return 32'd3 << (2 * ((a % 4) / 2));
    endfunction

    function automatic logic [31:0] exp_wdata(input logic [2:0] op, input logic [31:0] d);
        if (op == 3'd0) return (d % 256) * 32'h0101_0101;
        if (op == 3'd1) return (d % 65536) * 32'h0001_0001;
        return d;
    endfunction

    task automatic bubble();
        ex_opr_res = '0; ex_opr_b = '0; ex_rd = '0; ex_pc4 = '0;
        ex_rf_en = 1'b0; ex_dm_en = 1'b0; ex_wb_sel = '0; ex_lsuop = '0;
    endtask

    task automatic junk();
        ex_opr_res = $urandom; ex_opr_b = $urandom; ex_rd = 5'($urandom); ex_pc4 = $urandom;
        ex_rf_en = 1'($urandom); ex_dm_en = 1'($urandom);
        ex_wb_sel = 2'($urandom); ex_lsuop = 3'($urandom);
    endtask

    // Entered at a negedge with the stage idle; returns at a negedge after the follow-on ALU op.
    task automatic mem_access(input bit st, input logic [2:0] op, input logic [31:0] addr,
                              input logic [31:0] rs2, input logic [31:0] rdata,
                              input int waitc, input logic [4:0] rdn);
        logic [31:0] ea, fres, fpc;
        logic [4:0] frd;
        ea = addr - (addr % 4);
        ex_opr_res = addr; ex_opr_b = rs2; ex_rd = rdn; ex_pc4 = $urandom;
        ex_rf_en = !st; ex_dm_en = st; ex_wb_sel = st ? 2'b00 : 2'b10; ex_lsuop = op;
        @(posedge clk); #1 junk();
        @(negedge clk);
        chk("idle_req", dmem_req, 1);
        chk("idle_stall", stall, 1);
        chk("addr", dmem_addr, ea);
        chk("be", dmem_be, exp_be(st, op, addr));
        chk("we", dmem_we, st);
        if (st) chk("wdata", dmem_wdata, exp_wdata(op, rs2));
        chk("idle_fwd_en", fwd_rf_en, 0);
`ifdef MEM_MISALIGN_TRAP_EN
        chk("no_misalign", misalign, 0);
`endif
        @(posedge clk);
        for (int w = 0; w < waitc; w++) begin
            @(negedge clk);
            chk("wait_req", dmem_req, 1);
            chk("wait_stall", stall, 1);
            chk("wait_addr", dmem_addr, ea);
            chk("wait_held", fwd_opr_res, addr);
            @(posedge clk);
        end
        #1 dmem_rvalid = 1'b1; dmem_rdata = rdata;
        @(negedge clk);
        chk("busy_stall", stall, 1);
        @(posedge clk); #1 dmem_rvalid = 1'b0; dmem_rdata = $urandom;
        @(negedge clk);
        chk("done_stall", stall, 0);
        chk("done_req", dmem_req, 0);
        chk("done_wb_en", wb_rf_en, !st);
        chk("done_wb_rd", wb_rd, rdn);
        if (!st) chk("ld_data", wb_ld_data, exp_load(op, addr, rdata));
        fres = $urandom; fpc = $urandom; frd = 5'($urandom_range(1, 31));
        ex_opr_res = fres; ex_opr_b = $urandom; ex_rd = frd; ex_pc4 = fpc;
        ex_rf_en = 1'b1; ex_dm_en = 1'b0; ex_wb_sel = 2'($urandom_range(0, 1)); ex_lsuop = 3'($urandom);
        @(posedge clk);
        @(negedge clk);
        chk("follow_fwd_en", fwd_rf_en, 1);
        chk("follow_fwd_rd", fwd_rd, frd);
        chk("follow_fwd_res", fwd_opr_res, fres);
        chk("follow_pc4", wb_pc4, fpc);
        chk("follow_req", dmem_req, 0);
    endtask

    initial begin
        logic [2:0] lops [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
        rst_n = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = '0;
        bubble();
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_req", dmem_req, 0);
        chk("rst_stall", stall, 0);
        chk("rst_we", dmem_we, 0);
        chk("rst_be", dmem_be, 0);
        chk("rst_addr", dmem_addr, 0);
        chk("rst_wdata", dmem_wdata, 0);
        chk("rst_wb_en", wb_rf_en, 0);
        chk("rst_fwd_res", fwd_opr_res, 0);
        chk("rst_ld", wb_ld_data, 0);
        rst_n = 1'b1;
        ex_rd = 5'd5; ex_opr_res = 32'h7; ex_rf_en = 1'b1; ex_pc4 = 32'h44;
        @(posedge clk);
        @(negedge clk);
        chk("add_fwd_rd", fwd_rd, 5);
        chk("add_fwd_res", fwd_opr_res, 7);
        chk("add_fwd_en", fwd_rf_en, 1);
        chk("add_wb_en", wb_rf_en, 1);
        mem_access(0, 3'd2, 32'h104, 32'h0, 32'hDEAD_BEEF, 0, 5'd1);
        mem_access(0, 3'd0, 32'h203, 32'h0, 32'h80FF_0000, 0, 5'd2);
        mem_access(0, 3'd4, 32'h203, 32'h0, 32'h80FF_0000, 0, 5'd3);
        mem_access(0, 3'd5, 32'h202, 32'h0, 32'h80FF_0000, 1, 5'd4);
        mem_access(1, 3'd0, 32'h11, 32'h1234_56AB, 32'h0, 0, 5'd0);
        mem_access(1, 3'd1, 32'h12, 32'h1234_56AB, 32'h0, 2, 5'd0);
        mem_access(0, 3'd2, 32'h400, 32'h0, 32'h0BAD_F00D, 4, 5'd9);
`ifdef MEM_MISALIGN_TRAP_EN
        ex_opr_res = 32'h102; ex_rd = 5'd7; ex_rf_en = 1'b1; ex_dm_en = 1'b0;
        ex_wb_sel = 2'b10; ex_lsuop = 3'd2;
        @(posedge clk); #1 bubble();
        @(negedge clk);
        chk("mis_flag", misalign, 1);
        chk("mis_req", dmem_req, 0);
        chk("mis_stall", stall, 0);
        chk("mis_wb_en", wb_rf_en, 0);
        @(posedge clk);
        @(negedge clk);
        chk("mis_clear", misalign, 0);
        chk("mis_idle_req", dmem_req, 0);
`endif
        ex_opr_res = 32'h300; ex_rd = 5'd8; ex_rf_en = 1'b1; ex_dm_en = 1'b0;
        ex_wb_sel = 2'b10; ex_lsuop = 3'd2;
        @(posedge clk); #1 bubble();
        @(posedge clk); #1 rst_n = 1'b0;
        @(negedge clk);
        chk("pre_rst_busy", dmem_req, 1);
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        chk("mid_rst_req", dmem_req, 0);
        chk("mid_rst_stall", stall, 0);
        chk("mid_rst_addr", dmem_addr, 0);
        chk("mid_rst_be", dmem_be, 0);
        chk("mid_rst_fwd", fwd_opr_res, 0);
        chk("mid_rst_ld", wb_ld_data, 0);
        dmem_rvalid = 1'b1; dmem_rdata = 32'hCAFE_1234;
        @(posedge clk); #1 dmem_rvalid = 1'b0;
        @(negedge clk);
        chk("stray_ld", wb_ld_data, 0);
        chk("stray_stall", stall, 0);
        for (int i = 0; i < 40; i++) begin
            bit st;
            logic [2:0] op;
            logic [31:0] a;
            st = 1'($urandom_range(0, 1));
            op = st ? 3'($urandom_range(0, 2)) : lops[$urandom_range(0, 4)];
            a = $urandom;
`ifdef MEM_MISALIGN_TRAP_EN
            if (op[1:0] == 2'b01) a = a - (a % 2);
            if (op[1:0] == 2'b10) a = a - (a % 4);
`endif
            mem_access(st, op, a, $urandom, $urandom, $urandom_range(0, 3), 5'($urandom));
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
